// File: rtl/vscale_hasti_sram_slave.sv
// HASTI (AHB-lite) SRAM responder: pipelined two-phase transfers, programmable
// wait states, byte/half/word writes and a two-cycle ERROR response.
module vscale_hasti_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t        state;
  logic [AW+1:0] addr;
  logic          write;
  logic [2:0]    size;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          bad;
  logic          complete;
  logic [3:0]    be;
  logic [AW-1:0] widx;

  // A new address phase is only taken while our own data phase is finishing.
  always_comb begin
    accept   = hsel && hready && htrans[1] && hreadyout;
    bad      = (haddr >= LIMIT) || (hsize > 3'd2) ||
               ((hsize == 3'd1) && haddr[0]) ||
               ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    complete = (state == DATA) && (cnt == 4'd0);
    widx     = addr[AW+1:2];
  end

  always_comb begin
    be = 4'b1111;
    case (size)
      3'd0:    be = 4'b0001 << addr[1:0];
      3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    case (state)
      DATA:    hreadyout = (cnt == 4'd0);
      ERR1:    hreadyout = 1'b0;
      default: hreadyout = 1'b1;
    endcase
    hresp  = (state == ERR1) || (state == ERR2);
    hrdata = ((state == DATA) && !write) ? mem[widx] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      addr  <= '0;
      write <= 1'b0;
      size  <= 3'd0;
    end else if (accept) begin
      addr  <= haddr[AW+1:0];
      write <= hwrite;
      size  <= hsize;
      cnt   <= 4'(WAIT_STATES);
      state <= bad ? ERR1 : DATA;
    end else begin
      case (state)
        DATA: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never reset; a reset on the completing edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && complete && write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Directed bench for vscale_hasti_sram_slave: a zero-wait instance and a
// two-wait-state instance share the address/data bus, selected by hsel.
module tb_vscale_hasti_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic        use2;
  logic [31:0] rdata0, rdata2;
  logic        ready0, ready2;
  logic        resp0, resp2;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The bench plays the bus: hready follows whichever slave is in use.
  assign hready = use2 ? ready2 : ready0;

  vscale_hasti_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hrdata(rdata0), .hreadyout(ready0), .hresp(resp0)
  );

  vscale_hasti_sram_slave #(.DEPTH(16), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hrdata(rdata2), .hreadyout(ready2), .hresp(resp2)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic slow, input logic [31:0] a, input logic w,
                            input logic [2:0] s, input logic [1:0] t);
    use2   = slow;
    hsel0  = !slow;
    hsel2  = slow;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = t;
  endtask

  task automatic go_idle();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; use2 = 1'b0; hwdata = '0; haddr = '0; hsize = 3'd0;
    go_idle();
    step(); step();
    reset = 1'b0;
    check_output("rst_ready0", ready0, 1);
    check_output("rst_resp0", resp0, 0);
    check_output("rst_rdata0", rdata0, 0);
    check_output("rst_ready2", ready2, 1);

    // Word write then pipelined read of the same word.
    addr_phase(0, 32'h10, 1, 3'd2, 2'd2); step();
    hwdata = 32'hDEADBEEF;
    addr_phase(0, 32'h10, 0, 3'd2, 2'd2);
    check_output("wr_ready", ready0, 1);
    step();
    check_output("b2b_rdata", rdata0, 32'hDEADBEEF);
    check_output("b2b_ready", ready0, 1);
    go_idle(); step();
    check_output("idle_rdata", rdata0, 0);

    // Sub-word writes on their natural lanes.
    addr_phase(0, 32'h10, 1, 3'd2, 2'd2); step();
    hwdata = 32'h11223344;
    addr_phase(0, 32'h13, 1, 3'd0, 2'd2); step();
    hwdata = 32'hAA000000;
    addr_phase(0, 32'h10, 0, 3'd2, 2'd2); step();
    check_output("byte_wr", rdata0, 32'hAA223344);
    addr_phase(0, 32'h10, 1, 3'd1, 2'd2); step();
    hwdata = 32'h00005566;
    addr_phase(0, 32'h10, 0, 3'd2, 2'd2); step();
    check_output("half_wr", rdata0, 32'hAA225566);
    go_idle(); step();

    // Out-of-range read.
    addr_phase(0, 32'h1000, 0, 3'd2, 2'd2); step();
    check_output("range_err1_resp", resp0, 1);
    check_output("range_err1_ready", ready0, 0);
    step();
    check_output("range_err2_resp", resp0, 1);
    check_output("range_err2_ready", ready0, 1);
    go_idle(); step();
    check_output("range_after_resp", resp0, 0);

    // Misaligned word read, then a good read accepted from ERR2.
    addr_phase(0, 32'h2, 0, 3'd2, 2'd2); step();
    check_output("mis_err1_resp", resp0, 1);
    check_output("mis_err1_ready", ready0, 0);
    step();
    check_output("mis_err2_ready", ready0, 1);
    addr_phase(0, 32'h10, 0, 3'd2, 2'd2); step();
    check_output("post_err_resp", resp0, 0);
    check_output("post_err_rdata", rdata0, 32'hAA225566);
    go_idle(); step();

    // Bad writes (misaligned half, hsize=3) must leave memory alone.
    addr_phase(0, 32'h11, 1, 3'd1, 2'd2); step();
    hwdata = 32'hFFFFFFFF;
    check_output("half_mis_resp", resp0, 1);
    step();
    addr_phase(0, 32'h10, 1, 3'd3, 2'd2); step();
    check_output("size3_resp", resp0, 1);
    check_output("size3_ready", ready0, 0);
    step();
    check_output("size3_err2_resp", resp0, 1);
    addr_phase(0, 32'h10, 0, 3'd2, 2'd2); step();
    check_output("mem_unchanged", rdata0, 32'hAA225566);
    check_output("mem_unchanged_resp", resp0, 0);
    go_idle(); step();

    // Two wait states: write, then read held until the write completes.
    addr_phase(1, 32'h8, 1, 3'd2, 2'd2); step();
    check_output("ws_wr_ready_a", ready2, 0);
    hwdata = 32'h12345678;
    addr_phase(1, 32'h8, 0, 3'd2, 2'd2); step();
    check_output("ws_wr_ready_b", ready2, 0);
    step();
    check_output("ws_wr_ready_c", ready2, 1);
    step();
    check_output("ws_rd_ready_a", ready2, 0);
    go_idle(); step();
    check_output("ws_rd_ready_b", ready2, 0);
    step();
    check_output("ws_rd_ready_c", ready2, 1);
    check_output("ws_rd_data", rdata2, 32'h12345678);
    step();

    // Reset in the wait state of a write drops it.
    addr_phase(1, 32'h8, 1, 3'd2, 2'd2); step();
    hwdata = 32'hCAFEF00D;
    go_idle();
    check_output("rstw_ready_before", ready2, 0);
    reset = 1'b1; step();
    reset = 1'b0;
    check_output("rstw_ready", ready2, 1);
    check_output("rstw_resp", resp2, 0);
    check_output("rstw_rdata", rdata2, 0);
    addr_phase(1, 32'h8, 0, 3'd2, 2'd1); step();
    check_output("busy_ready", ready2, 1);
    check_output("busy_resp", resp2, 0);
    check_output("busy_rdata", rdata2, 0);
    addr_phase(1, 32'h8, 0, 3'd2, 2'd2); step();
    go_idle(); step(); step();
    check_output("rstw_kept_ready", ready2, 1);
    check_output("rstw_kept_data", rdata2, 32'h12345678);
    step();

    // Range limit on the small instance is 4*16 bytes.
    addr_phase(1, 32'h40, 0, 3'd2, 2'd2); step();
    check_output("small_range_resp", resp2, 1);
    step();
    go_idle(); step();
    check_output("small_range_after", resp2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
